blur_frame_ctrl: RTL and testbench

BLUR_FRAME_CTRL -- requirements
Module: blur_frame_ctrl

---
 rtl/blur_pkg.sv | 42 ++++
 rtl/blur_frame_ctrl_if.sv | 36 +++
 rtl/blur_addr_gen.sv | 50 +++++
 rtl/blur_frame_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_blur_frame_ctrl.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/blur_pkg.sv
// Shared types and constants for the 3x3 box-blur frame controller.
// The state list gains StClear only when BLUR_BORDER_CLEAR_EN is defined.
package blur_pkg;

    typedef enum logic [2:0] {
        StIdle,
`ifdef BLUR_BORDER_CLEAR_EN
        StClear,
`endif
        StLoad,
        StCalc,
        StOut,
        StDone
    } state_e;

    localparam int unsigned NumTaps = 9;

    // Row-major 3x3 neighbourhood, top-left first
    localparam int TapRow [NumTaps] = '{-1, -1, -1, 0, 0, 0, 1, 1, 1};
    localparam int TapCol [NumTaps] = '{-1, 0, 1, -1, 0, 1, -1, 0, 1};

    function automatic int unsigned pad_width(int unsigned w);
        return w + 2;
    endfunction

    function automatic int unsigned pad_size(int unsigned w, int unsigned h);
        return (w + 2) * (h + 2);
    endfunction

    function automatic int unsigned frame_beats(int unsigned w, int unsigned h);
        return w * h * 3;
    endfunction

    function automatic int tap_offset(logic [3:0] k, int unsigned w2);
        return TapRow[k] * int'(w2) + TapCol[k];
    endfunction

    function automatic logic [3:0] div9(logic [7:0] s);
        return 4'(s / 8'd9);
    endfunction

endpackage

// File: rtl/blur_frame_ctrl_if.sv
// Pixel-in, padded-buffer and pixel-out signals of the blur controller.
// master = controller side, slave = stream source/sink and buffer side.
interface blur_frame_ctrl_if #(
    parameter int unsigned ADDR_W = 17
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        data_in;

    logic              mem_wr_en;
    logic [1:0]        mem_wr_ch;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [3:0]        mem_wr_data;

    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [11:0]       mem_rd_data;

    logic              out_valid;
    logic              out_ready;
    logic [3:0]        data_out_R;
    logic [3:0]        data_out_G;
    logic [3:0]        data_out_B;

    modport master (
        input  in_valid, data_in, mem_rd_data, out_ready,
        output in_ready, mem_wr_en, mem_wr_ch, mem_wr_addr, mem_wr_data,
        output mem_rd_en, mem_rd_addr, out_valid, data_out_R, data_out_G, data_out_B
    );

    modport slave (
        output in_valid, data_in, mem_rd_data, out_ready,
        input  in_ready, mem_wr_en, mem_wr_ch, mem_wr_addr, mem_wr_data,
        input  mem_rd_en, mem_rd_addr, out_valid, data_out_R, data_out_G, data_out_B
    );
endinterface

// File: rtl/blur_addr_gen.sv
// Padded-buffer pointer: walks interior pixels skipping the 2-wide border,
// and forms the 3x3 tap address around the current pointer.
module blur_addr_gen
    import blur_pkg::*;
#(
    parameter int unsigned Width  = 400,
    parameter int unsigned ADDR_W = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic              step,
    input  logic [3:0]        tap,
    output logic [ADDR_W-1:0] ptr,
    output logic [ADDR_W-1:0] tap_addr
);
    localparam int unsigned     ColW      = (Width > 1) ? $clog2(Width) : 1;
    localparam logic [ADDR_W-1:0] FirstAddr = ADDR_W'(Width + 3);

    logic [ColW-1:0]   col_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [3:0]        tap_sel;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
            col_q <= '0;
        end else if (init) begin
            ptr_q <= FirstAddr;
            col_q <= '0;
        end else if (step) begin
            if (col_q == ColW'(Width - 1)) begin
                ptr_q <= ptr_q + ADDR_W'(3);
                col_q <= '0;
            end else begin
                ptr_q <= ptr_q + ADDR_W'(1);
                col_q <= col_q + ColW'(1);
            end
        end
    end

    // Out-of-range tap indices fall back to the centre
    always_comb begin
        tap_sel  = (tap < 4'd9) ? tap : 4'd4;
        tap_addr = ptr_q + ADDR_W'(tap_offset(tap_sel, pad_width(Width)));
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/blur_frame_ctrl.sv
// 3x3 box-blur frame controller: loads a padded RGB buffer, then reads nine
// taps per pixel and streams floor(sum/9). Option: BLUR_BORDER_CLEAR_EN.
module blur_frame_ctrl
    import blur_pkg::*;
#(
    parameter int unsigned Width  = 400,
    parameter int unsigned Height = 300,
    parameter int unsigned ADDR_W = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    blur_frame_ctrl_if.master bus,
    output logic              busy,
    output logic              frame_done
);
    localparam int unsigned NumPix     = Width * Height;
    localparam int unsigned FrameBeats = frame_beats(Width, Height);
    localparam int unsigned BeatCntW   = $clog2(FrameBeats + 1);
    localparam int unsigned PixW       = $clog2(NumPix + 1);
`ifdef BLUR_BORDER_CLEAR_EN
    localparam int unsigned PadSize    = pad_size(Width, Height);
    logic [ADDR_W-1:0] clr_q;
`endif

    state_e state_q, state_d;

    logic [1:0]          ch_q;
    logic [BeatCntW-1:0] beat_q;
    logic [PixW-1:0]     pix_q;
    logic [3:0]          tap_q;
    logic [7:0]          sum_r_q, sum_g_q, sum_b_q;
    logic [3:0]          out_r_q, out_g_q, out_b_q;

    logic accept, last_beat, handshake, last_pix, rd_en, ag_init, ag_step;
    logic [ADDR_W-1:0] wr_ptr, tap_addr;

    blur_addr_gen #(
        .Width  (Width),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk      (clk),
        .reset    (reset),
        .init     (ag_init),
        .step     (ag_step),
        .tap      (tap_q),
        .ptr      (wr_ptr),
        .tap_addr (tap_addr)
    );

    assign accept    = (state_q == StLoad) && bus.in_valid;
    assign last_beat = accept && (beat_q == BeatCntW'(FrameBeats - 1));
    assign handshake = (state_q == StOut) && bus.out_ready;
    assign last_pix  = (pix_q == PixW'(NumPix - 1));
    // Taps 0..8 issue reads; 9 collects the last return, 10 registers the result
    assign rd_en     = (state_q == StCalc) && (tap_q < 4'd9);

    always_comb begin
        state_d = state_q;
        ag_init = 1'b0;
        ag_step = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
`ifdef BLUR_BORDER_CLEAR_EN
                    state_d = StClear;
`else
                    state_d = StLoad;
                    ag_init = 1'b1;
`endif
                end
            end
`ifdef BLUR_BORDER_CLEAR_EN
            StClear: begin
                if (clr_q == ADDR_W'(PadSize - 1)) begin
                    state_d = StLoad;
                    ag_init = 1'b1;
                end
            end
`endif
            StLoad: begin
                ag_step = accept && (ch_q == 2'd2);
                // Pointer is reused as the CALC centre, so rewind it here
                if (last_beat) begin
                    state_d = StCalc;
                    ag_init = 1'b1;
                end
            end
            StCalc: begin
                if (tap_q == 4'd10) state_d = StOut;
            end
            StOut: begin
                if (handshake) begin
                    ag_step = 1'b1;
                    state_d = last_pix ? StDone : StCalc;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.in_ready    = (state_q == StLoad);
        bus.mem_wr_en   = accept;
        bus.mem_wr_ch   = accept ? ch_q : 2'd0;
        bus.mem_wr_addr = accept ? wr_ptr : '0;
        bus.mem_wr_data = accept ? bus.data_in : 4'd0;
`ifdef BLUR_BORDER_CLEAR_EN
        if (state_q == StClear) begin
            bus.mem_wr_en   = 1'b1;
            bus.mem_wr_ch   = 2'd3;
            bus.mem_wr_addr = clr_q;
            bus.mem_wr_data = 4'd0;
        end
`endif
        bus.mem_rd_en   = rd_en;
        bus.mem_rd_addr = rd_en ? tap_addr : '0;
        bus.out_valid   = (state_q == StOut);
        bus.data_out_R  = out_r_q;
        bus.data_out_G  = out_g_q;
        bus.data_out_B  = out_b_q;
        busy            = (state_q != StIdle);
        frame_done      = (state_q == StDone);
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ch_q    <= '0;
            beat_q  <= '0;
            pix_q   <= '0;
            tap_q   <= '0;
            sum_r_q <= '0;
            sum_g_q <= '0;
            sum_b_q <= '0;
            out_r_q <= '0;
            out_g_q <= '0;
            out_b_q <= '0;
`ifdef BLUR_BORDER_CLEAR_EN
            clr_q   <= '0;
`endif
        end else begin
            if (state_q == StIdle) begin
                ch_q   <= '0;
                beat_q <= '0;
                pix_q  <= '0;
                tap_q  <= '0;
`ifdef BLUR_BORDER_CLEAR_EN
                clr_q  <= '0;
`endif
            end
`ifdef BLUR_BORDER_CLEAR_EN
            if (state_q == StClear) clr_q <= clr_q + ADDR_W'(1);
`endif
            if (accept) begin
                ch_q   <= (ch_q == 2'd2) ? 2'd0 : ch_q + 2'd1;
                beat_q <= beat_q + BeatCntW'(1);
            end
            if (state_q == StCalc) begin
                if (tap_q == 4'd10) begin
                    tap_q   <= '0;
                    out_r_q <= div9(sum_r_q);
                    out_g_q <= div9(sum_g_q);
                    out_b_q <= div9(sum_b_q);
                end else begin
                    tap_q <= tap_q + 4'd1;
                end
                // Read data lags the tap counter by one cycle
                if (tap_q == 4'd0) begin
                    sum_r_q <= '0;
                    sum_g_q <= '0;
                    sum_b_q <= '0;
                end else if (tap_q <= 4'd9) begin
                    sum_r_q <= sum_r_q + {4'd0, bus.mem_rd_data[11:8]};
                    sum_g_q <= sum_g_q + {4'd0, bus.mem_rd_data[7:4]};
                    sum_b_q <= sum_b_q + {4'd0, bus.mem_rd_data[3:0]};
                end
            end
            if (handshake) pix_q <= pix_q + PixW'(1);
        end
    end

endmodule

// File: tb/tb_blur_frame_ctrl.sv
// Self-checking bench for blur_frame_ctrl at 4x3 with a 1-cycle model RAM.
// Define BLUR_BORDER_CLEAR_EN to exercise the border-clear build.
module tb_blur_frame_ctrl;
    localparam int W    = 4;
    localparam int H    = 3;
    localparam int AW   = 5;
    localparam int NPIX = W * H;
    localparam int NBEAT = NPIX * 3;
`ifdef BLUR_BORDER_CLEAR_EN
    localparam int unsigned ExpClr     = 30;
    localparam logic [11:0] PreloadVal = 12'hFFF;
`else
    localparam int unsigned ExpClr     = 0;
    localparam logic [11:0] PreloadVal = 12'h000;
`endif

    logic clk = 1'b0;
    logic reset, start, busy, frame_done;
    logic preload_go;

    blur_frame_ctrl_if #(.ADDR_W(AW)) bus_if ();

    blur_frame_ctrl #(
        .Width  (W),
        .Height (H),
        .ADDR_W (AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .bus        (bus_if),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Model padded buffer, {R,G,B} per word
    logic [11:0] ram [32];
    always @(posedge clk) begin
        if (preload_go) begin
            for (int i = 0; i < 32; i++) ram[i] <= PreloadVal;
        end else if (bus_if.mem_wr_en) begin
            case (bus_if.mem_wr_ch)
                2'd0: ram[bus_if.mem_wr_addr][11:8] <= bus_if.mem_wr_data;
                2'd1: ram[bus_if.mem_wr_addr][7:4]  <= bus_if.mem_wr_data;
                2'd2: ram[bus_if.mem_wr_addr][3:0]  <= bus_if.mem_wr_data;
                default: ram[bus_if.mem_wr_addr] <= {3{bus_if.mem_wr_data}};
            endcase
        end
        if (bus_if.mem_rd_en) bus_if.mem_rd_data <= ram[bus_if.mem_rd_addr];
    end

    // Reference image: img[pixel][channel], channel 0=R 1=G 2=B
    logic [3:0] img [NPIX][3];

    function automatic logic [11:0] model_out(int y);
        int row, col, r, c;
        int s [3];
        row = y / W;
        col = y % W;
        for (int ch = 0; ch < 3; ch++) s[ch] = 0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                r = row + dr;
                c = col + dc;
                if (r >= 0 && r < H && c >= 0 && c < W)
                    for (int ch = 0; ch < 3; ch++) s[ch] += int'(img[r * W + c][ch]);
            end
        end
        return {4'(s[0] / 9), 4'(s[1] / 9), 4'(s[2] / 9)};
    endfunction

    function automatic int pad_addr(int p);
        return (p / W + 1) * (W + 2) + (p % W) + 1;
    endfunction

    function automatic logic [31:0] idle_vec();
        return {4'd0, busy, frame_done, bus_if.in_ready, bus_if.out_valid,
                bus_if.mem_wr_en, bus_if.mem_rd_en, bus_if.data_out_R, bus_if.data_out_G,
                bus_if.data_out_B, bus_if.mem_wr_addr, bus_if.mem_rd_addr};
    endfunction

    logic [10:0] wr_q [$];
    logic [11:0] out_q [$];
    int unsigned clr_cnt = 0;
    int unsigned done_cnt = 0;
    int unsigned hold_cnt = 0;
    logic prev_ir = 1'b0, prev_ov = 1'b0, prev_or = 1'b0;
    logic [11:0] prev_data = '0;

    always @(negedge clk) begin
        if (bus_if.mem_wr_en) begin
            if (bus_if.mem_wr_ch == 2'd3) begin
                check_val("clear_addr", 32'(bus_if.mem_wr_addr), clr_cnt);
                check_val("clear_data", 32'(bus_if.mem_wr_data), 0);
                clr_cnt++;
            end else begin
                wr_q.push_back({bus_if.mem_wr_addr, bus_if.mem_wr_ch, bus_if.mem_wr_data});
            end
        end
        if (!reset && bus_if.in_ready && !prev_ir) check_val("clear_before_load", clr_cnt, ExpClr);
        if (!reset && prev_ov && !prev_or)
            check_val("hold_stable",
                      {19'd0, bus_if.out_valid, bus_if.data_out_R, bus_if.data_out_G,
                       bus_if.data_out_B}, {19'd0, 1'b1, prev_data});
        if (bus_if.out_valid && bus_if.out_ready)
            out_q.push_back({bus_if.data_out_R, bus_if.data_out_G, bus_if.data_out_B});
        if (frame_done) done_cnt++;
        prev_ir   = bus_if.in_ready;
        prev_ov   = bus_if.out_valid;
        prev_or   = bus_if.out_ready;
        prev_data = {bus_if.data_out_R, bus_if.data_out_G, bus_if.data_out_B};
    end

    task automatic feed(input int valid_mode, input bit start_mid);
        int i = 0;
        int cyc = 0;
        bit did = 0;
        while (i < NBEAT && cyc < 3000) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (start_mid && i == 10 && !did) begin
                start = 1'b1;
                did = 1;
            end
            if (valid_mode == 1 && $urandom_range(0, 3) == 0) begin
                bus_if.in_valid = 1'b0;
            end else begin
                bus_if.in_valid = 1'b1;
                bus_if.data_in  = img[i / 3][i % 3];
            end
            @(negedge clk);
            cyc++;
            if (bus_if.in_valid && bus_if.in_ready) i++;
        end
        if (i < NBEAT) check_val("feed_timeout", i, NBEAT);
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic sink(input int ready_mode, input int stop_at);
        int got = 0;
        int cyc = 0;
        hold_cnt = 0;
        while (got < stop_at && cyc < 3000) begin
            @(posedge clk); #1;
            case (ready_mode)
                1:       bus_if.out_ready = 1'($urandom_range(0, 1));
                2:       bus_if.out_ready = (got == 2 && hold_cnt < 5) ? 1'b0 : 1'b1;
                default: bus_if.out_ready = 1'b1;
            endcase
            @(negedge clk);
            cyc++;
            if (bus_if.out_valid && !bus_if.out_ready && got == 2) hold_cnt++;
            if (bus_if.out_valid && bus_if.out_ready) got++;
        end
        if (got < stop_at) check_val("sink_timeout", got, stop_at);
    endtask

    task automatic run_frame(input int ready_mode, input int valid_mode, input bit start_mid,
                             input int stop_at);
        int unsigned d0;
        logic [10:0] exp_wr;
        out_q.delete();
        wr_q.delete();
        clr_cnt = 0;
        d0 = done_cnt;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        fork
            feed(valid_mode, start_mid);
            sink(ready_mode, stop_at);
        join
        if (stop_at < NPIX) begin
            @(posedge clk); #1;
            bus_if.out_ready = 1'b0;
            @(negedge clk);
            check_val("mid_calc", {30'd0, busy, bus_if.out_valid}, 32'h2);
            @(posedge clk); #1;
            reset = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check_val("abort_idle", idle_vec(), 0);
            @(posedge clk); #1;
            reset = 1'b0;
            check_val("abort_no_done", done_cnt - d0, 0);
        end else begin
            @(negedge clk);
            check_val("frame_done_pulse", 32'(frame_done), 1);
            @(posedge clk); #1;
            bus_if.out_ready = 1'b0;
            @(negedge clk);
            check_val("frame_done_end", {30'd0, frame_done, busy}, 0);
            check_val("done_pulses", done_cnt - d0, 1);
            check_val("out_count", out_q.size(), NPIX);
            for (int k = 0; k < out_q.size() && k < NPIX; k++)
                check_val($sformatf("pix%0d", k), 32'(out_q[k]), 32'(model_out(k)));
            check_val("wr_count", wr_q.size(), NBEAT);
            for (int k = 0; k < wr_q.size() && k < NBEAT; k++) begin
                exp_wr = {5'(pad_addr(k / 3)), 2'(k % 3), img[k / 3][k % 3]};
                check_val($sformatf("wr%0d", k), 32'(wr_q[k]), 32'(exp_wr));
            end
            check_val("clr_count", clr_cnt, ExpClr);
        end
    endtask

    task automatic fill_img(input bit all_f);
        for (int p = 0; p < NPIX; p++)
            for (int ch = 0; ch < 3; ch++)
                img[p][ch] = all_f ? 4'hF : 4'($urandom_range(0, 15));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int exp_addr [12] = '{7, 8, 9, 10, 13, 14, 15, 16, 19, 20, 21, 22};
        logic [10:0] w;
        reset = 1'b1;
        start = 1'b0;
        preload_go = 1'b1;
        bus_if.in_valid  = 1'b0;
        bus_if.data_in   = 4'd0;
        bus_if.out_ready = 1'b0;
        @(posedge clk); #1;
        preload_go = 1'b0;
        @(negedge clk);
        check_val("reset_state", idle_vec(), 0);
        // Reset and start together: reset must win
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check_val("reset_beats_start", 32'(busy), 0);

        // Flat white image, always ready
        fill_img(1'b1);
        run_frame(0, 0, 1'b0, NPIX);
        if (out_q.size() == NPIX) begin
            check_val("interior_y5", 32'(out_q[5]), 32'h0FFF);
            check_val("corner_y0", 32'(out_q[0]), 32'h0666);
        end

        // Stream beats while idle: must be ignored
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            bus_if.in_valid = 1'b1;
            bus_if.data_in  = 4'h5;
            @(negedge clk);
            check_val("idle_in_valid", {29'd0, busy, bus_if.in_ready, bus_if.mem_wr_en}, 0);
        end
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;

        // Random image, random valid/ready, stray start mid-load
        fill_img(1'b0);
        run_frame(1, 1, 1'b1, NPIX);
        if (wr_q.size() == NBEAT)
            for (int j = 0; j < 12; j++) begin
                w = wr_q[3 * j];
                check_val($sformatf("wr_addr%0d", j), 32'(w[10:6]), exp_addr[j]);
            end

        // Back-pressure on pixel 2
        fill_img(1'b0);
        run_frame(2, 0, 1'b0, NPIX);
        check_val("hold_cycles", hold_cnt, 5);

        // Abort mid-CALC at y=4, then a full frame
        fill_img(1'b0);
        run_frame(0, 0, 1'b0, 4);
        fill_img(1'b0);
        run_frame(1, 1, 1'b0, NPIX);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
